// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 8;
    localparam int DIGI_W = DIGITS + SEG_W;

    typedef logic [DIGI_W-1:0] digi_t;
    typedef logic [SEG_W-1:0]  seg_t;

    // Whole display dark: every select and every segment high (active-low).
    localparam digi_t ALL_OFF = 12'hFFF;

    // Segments a..g all off, used for leading-zero blanking.
    localparam logic [6:0] SEG_DARK = 7'h7F;

    // Active-low a..g patterns for hex glyphs, element n is the glyph of nibble n.
    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_if.sv
// Host-side bus of the display scanner: value/mask load, controls and drive outputs.
// Latency: n/a (wiring only).
// Backpressure: none; loads are always accepted.
interface seg7_if;
    import seg7_pkg::*;

    logic [15:0] iValue;
    logic [3:0]  iDpMask;
    logic        iLoad;
    logic        iBlankLZ;
    logic        iEnable;
    digi_t       oDigi;
    logic        oFrame;

    // Host side drives value and controls, observes the display drive.
    modport master (
        output iValue, iDpMask, iLoad, iBlankLZ, iEnable,
        input  oDigi, oFrame
    );

    // Scanner side.
    modport slave (
        input  iValue, iDpMask, iLoad, iBlankLZ, iEnable,
        output oDigi, oFrame
    );

endinterface

// File: rtl/seg7_hexdec.sv
// Hex nibble to active-low seven-segment glyph, with decimal point on bit 7.
// Latency: purely combinational.
// Backpressure: none.
module seg7_hexdec
    import seg7_pkg::*;
(
    input  logic [3:0] iNibble,
    input  logic       iDp,
    output seg_t       oSeg
);

    // Table lookup; dp is active-low like the segments.
    always_comb begin
        oSeg = {~iDp, GLYPH_TBL[iNibble]};
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit hex display driver with double-buffered value and frame commit.
// Latency: oDigi/oFrame registered, one cycle after the slot counter/digit index.
// Backpressure: none; iLoad is always accepted, the last load before a frame boundary wins.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
)(
    input  logic  iClk,
    input  logic  iRst,
    seg7_if.slave bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;

    // Displayed value only changes at frame boundaries; pending holds the next one.
    logic [15:0] actVal;
    logic [3:0]  actMask;
    logic [15:0] pendVal;
    logic [3:0]  pendMask;
    logic        pendFlag;

    logic        slotEnd;
    logic        frameWrap;
    logic        commit;
    logic [3:0]  upperZero;
    logic        lzBlank;
    logic [3:0]  curNibble;
    logic        curDp;
    seg_t        glyphSeg;
    seg_t        segNext;
    logic [3:0]  selNext;
    digi_t       digiNext;

    // Slot end, frame wrap and commit qualifiers; everything is frozen while disabled.
    always_comb begin
        slotEnd   = bus.iEnable && (cnt == CNT_LAST);
        frameWrap = slotEnd && (idx == 2'd3);
        commit    = frameWrap && (pendFlag || bus.iLoad);
    end

    // Slot counter and digit index.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (bus.iEnable) begin
            if (slotEnd) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Pending capture and frame commit; a load in the commit cycle bypasses straight to active.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pendVal  <= 16'h0000;
            pendMask <= 4'h0;
            pendFlag <= 1'b0;
            actVal   <= 16'h0000;
            actMask  <= 4'h0;
        end else begin
            if (bus.iLoad) begin
                pendVal  <= bus.iValue;
                pendMask <= bus.iDpMask;
            end
            if (commit) begin
                actVal   <= bus.iLoad ? bus.iValue  : pendVal;
                actMask  <= bus.iLoad ? bus.iDpMask : pendMask;
                pendFlag <= 1'b0;
            end else if (bus.iLoad) begin
                pendFlag <= 1'b1;
            end
        end
    end

    // Leading-zero detection: upperZero[k] means active nibbles k..3 are all zero.
    always_comb begin
        upperZero[3] = (actVal[15:12] == 4'h0);
        upperZero[2] = upperZero[3] && (actVal[11:8] == 4'h0);
        upperZero[1] = upperZero[2] && (actVal[7:4] == 4'h0);
        upperZero[0] = 1'b0;
        lzBlank      = bus.iBlankLZ && upperZero[idx];
        curNibble    = actVal[{idx, 2'b00} +: 4];
        curDp        = actMask[idx];
    end

    seg7_hexdec u_hexdec (
        .iNibble (curNibble),
        .iDp     (curDp),
        .oSeg    (glyphSeg)
    );

    // Next display word: dark while disabled or in the anti-ghost gap, else one digit selected.
    always_comb begin
        selNext = ~(4'b0001 << idx);
        segNext = glyphSeg;
        if (lzBlank) begin
            segNext[6:0] = SEG_DARK;
        end
        if (!bus.iEnable || (cnt < GAP_END)) begin
            digiNext = ALL_OFF;
        end else begin
            digiNext = {selNext, segNext};
        end
    end

    // Output registers; oFrame marks the first cycle of each new frame.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            bus.oDigi  <= ALL_OFF;
            bus.oFrame <= 1'b0;
        end else begin
            bus.oDigi  <= digiNext;
            bus.oFrame <= frameWrap;
        end
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot (at least 4).
REQ-002 Parameter BLANK_CYC, default 500, anti-ghost gap cycles at the start of each slot (1 <= BLANK_CYC < SCAN_DIV).
REQ-003 iClk  in  1  system clock; the single clock of the block.
REQ-004 iRst  in  1  reset, synchronous and active-high.
REQ-005 iValue  in  16  four hex nibbles; nibble k drives digit k, digit 0 is least significant.
REQ-006 iDpMask  in  4  decimal-point enables, bit k drives digit k, active-high.
REQ-007 iLoad  in  1  single-cycle strobe; captures iValue and iDpMask into the pending register.
REQ-008 iBlankLZ  in  1  leading-zero blanking enable.
REQ-009 iEnable  in  1  scan enable; low freezes the scan and darkens the display.
REQ-010 oDigi  out  12  bits [11:8] digit select, active-low, bit 8 = digit 0; bits [7:0] segments, active-low, bit0=a … bit6=g, bit7=dp.
REQ-011 oFrame  out  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Slot counter cnt SHALL count 0..SCAN_DIV-1 while iEnable=1, then wrap to 0; on wrap, digit index idx SHALL advance 0→1→2→3→0.
REQ-013 oDigi SHALL be registered, one cycle of latency from cnt/idx/active value.
REQ-014 oDigi SHALL be 12'hFFF when iEnable=0 or cnt<BLANK_CYC.
REQ-015 Otherwise oDigi[11:8] SHALL be low only at bit 8+idx, and oDigi[7:0] SHALL show the hex glyph of active nibble idx, with dp on when the active dp bit idx is 1.
REQ-016 Glyph table, active-low segment bits [6:0] = 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
REQ-017 Leading-zero blanking: with iBlankLZ=1, digit k (k=3..1) SHALL be blanked when active nibbles k..3 are all zero; the select bit stays driven and segments[6:0]=7'h7F; dp still follows the mask; digit 0 is never blanked.
REQ-018 iLoad=1 SHALL write pending value/mask and set the pending flag; with multiple loads in one frame, the last one wins.
REQ-019 Frame commit: in the cycle where cnt=SCAN_DIV-1 and idx=3 with iEnable=1, if the pending flag is set (or iLoad=1 in that cycle), active ← pending and the flag SHALL clear.
REQ-020 Simultaneous iLoad and commit: the iValue/iDpMask of that cycle SHALL be committed directly (bypass), and the flag SHALL end cleared.
REQ-021 The active value SHALL never change mid-frame (no tearing).
REQ-022 oFrame SHALL be registered and assert for exactly one cycle, the cycle after every idx 3→0 wrap, whether or not a commit occurred.
REQ-023 While iEnable=0: cnt, idx and active SHALL hold; iLoad SHALL still update pending; oFrame=0.
REQ-024 Re-enabling SHALL resume from the held cnt/idx.

Reset
REQ-025 While iRst=1 at a rising edge of iClk: cnt=0, idx=0, active value=16'h0000, active mask=4'h0, pending cleared with flag=0, oDigi=12'hFFF, oFrame=0; iLoad is ignored.
REQ-026 Reset mid-frame SHALL discard the pending value; the scan SHALL restart at digit 0, slot cycle 0, on the first cycle after iRst falls.

Structure
REQ-027 Package seg7_pkg SHALL hold the glyph table constants, the all-off value 12'hFFF, and digit/segment width constants.
REQ-028 The glyph lookup SHALL be one combinational sub-module, seg7_hexdec (4-bit nibble + dp in, 8-bit segments out); counters, pending/active registers and output registers live in seg7_scan.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-029 Assert iRst for 3 cycles → oDigi=12'hFFF and oFrame=0 throughout and on the first cycle after release.
REQ-030 Load 16'h1234, mask 0, iBlankLZ=0, after reset → first frame shows 0000 (digit 0 = 12'hEC0); from the second frame digit 0 = 12'hE99 and digit 3 = 12'h7F9; the gap cycles of every slot read 12'hFFF.
REQ-031 Load 16'h000A, mask 4'b0001, iBlankLZ=1 → digits 3,2,1 = 12'h7FF, 12'hBFF, 12'hDFF; digit 0 = 12'hE08.
REQ-032 Load 16'h5555 mid-frame, then 16'h6666 in the commit cycle → no glyph change mid-frame; next frame shows 6666 (digit 0 = 12'hE82); oFrame pulses once per 32 cycles.
REQ-033 Drop iEnable during digit 2 for 20 cycles while loading 16'hFFFF → oDigi=12'hFFF and oFrame=0 while low; the scan resumes at digit 2 with the held cnt; FFFF is shown only after the next frame commit.
REQ-034 Assert iRst during digit 2 with a pending load → after release, oDigi=12'hFFF for 3 cycles (reset cycle plus the 2-cycle gap), then digit 0 shows 0 (12'hEC0); the pending value never appears.
